// File: rtl/range_sched.sv
// Round-robin scheduler sharing one range-finder core between NUM_REQ sample streams.
// Optional stall timeout with post-timeout drain is enabled by defining RSCHED_TIMEOUT_EN.
module range_sched #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           rf_data,
    output logic                       rf_go,
    output logic                       rf_finish,
    input  logic [WIDTH-1:0]           rf_range,
    input  logic                       rf_error,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [WIDTH-1:0]           res_range,
    output logic                       res_err,
    output logic                       busy
);
    localparam int unsigned IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT == 0) begin : g_bad_cfg
        $error("range_sched: unsupported NUM_REQ or TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_STREAM,
        S_FLUSH,
        S_WAIT,
        S_HOLD
`ifdef RSCHED_TIMEOUT_EN
        , S_DRAIN
`endif
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gnt;
    logic [WIDTH-1:0] r_anchor;
    logic             r_err_acc;
    logic             r_res_valid;
    logic [IDW-1:0]   r_res_id;
    logic [WIDTH-1:0] r_res_range;
    logic             r_res_err;
    logic             r_busy;

    logic             w_found;
    logic [IDW-1:0]   w_pick;
    logic [IDW-1:0]   w_gnt_inc;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_open;

`ifdef RSCHED_TIMEOUT_EN
    localparam int unsigned STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [STALL_W-1:0] r_stall;
    logic               r_drain;
    logic               w_timeout;

    // Fires on the TIMEOUT-th consecutive empty cycle of FIRST or STREAM.
    assign w_timeout = (r_state == S_FIRST || r_state == S_STREAM) && !w_sel_valid &&
                       (r_stall == STALL_W'(TIMEOUT - 1));
    assign w_open    = (r_state == S_FIRST) || (r_state == S_STREAM) || (r_state == S_DRAIN);
`else
    assign w_open    = (r_state == S_FIRST) || (r_state == S_STREAM);
`endif

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_range = r_res_range;
    assign res_err   = r_res_err;
    assign busy      = r_busy;
    assign w_gnt_inc = (r_gnt == IDW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;

    // First valid requester at or after the round-robin pointer.
    always_comb begin : rr_pick
        int unsigned k;
        k       = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            k = 32'(r_ptr) + unsigned'(i);
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!w_found && req_valid[IDW'(k)]) begin
                w_found = 1'b1;
                w_pick  = IDW'(k);
            end
        end
    end

    always_comb begin : sel_mux
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        req_ready   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_gnt == IDW'(i)) begin
                w_sel_valid  = req_valid[i];
                w_sel_last   = req_last[i];
                w_sel_data   = req_data[i*WIDTH +: WIDTH];
                req_ready[i] = w_open;
            end
        end
    end

    // Core drive: the beat passes straight through; stalls and flush replay the anchor.
    always_comb begin : core_drive
        rf_go     = 1'b0;
        rf_finish = 1'b0;
        rf_data   = '0;
        case (r_state)
            S_FIRST: begin
                if (w_sel_valid) begin
                    rf_go   = 1'b1;
                    rf_data = w_sel_data;
                end
            end
            S_STREAM: begin
                if (w_sel_valid) begin
                    rf_data   = w_sel_data;
                    rf_finish = w_sel_last;
                end else begin
                    rf_data   = r_anchor;
`ifdef RSCHED_TIMEOUT_EN
                    rf_finish = w_timeout;
`endif
                end
            end
            S_FLUSH: begin
                rf_data   = r_anchor;
                rf_finish = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_anchor    <= '0;
            r_err_acc   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_range <= '0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef RSCHED_TIMEOUT_EN
            r_stall     <= '0;
            r_drain     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= w_pick;
                        r_err_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_FIRST;
`ifdef RSCHED_TIMEOUT_EN
                        r_stall   <= '0;
`endif
                    end
                end
                S_FIRST: begin
                    if (w_sel_valid) begin
                        r_anchor  <= w_sel_data;
                        r_err_acc <= rf_error;
                        r_state   <= w_sel_last ? S_FLUSH : S_STREAM;
`ifdef RSCHED_TIMEOUT_EN
                        r_stall   <= '0;
`endif
                    end else begin
                        r_err_acc <= r_err_acc | rf_error;
`ifdef RSCHED_TIMEOUT_EN
                        if (w_timeout) begin
                            r_ptr   <= w_gnt_inc;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stall <= r_stall + 1'b1;
                        end
`endif
                    end
                end
                S_STREAM: begin
                    r_err_acc <= r_err_acc | rf_error;
                    if (w_sel_valid) begin
`ifdef RSCHED_TIMEOUT_EN
                        r_stall <= '0;
`endif
                        if (w_sel_last) r_state <= S_WAIT;
                    end
`ifdef RSCHED_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_err_acc <= 1'b1;
                        r_drain   <= 1'b1;
                        r_state   <= S_WAIT;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                S_FLUSH: begin
                    r_err_acc <= r_err_acc | rf_error;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_res_range <= rf_range;
                    r_res_id    <= r_gnt;
                    r_res_err   <= r_err_acc | rf_error;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= w_gnt_inc;
`ifdef RSCHED_TIMEOUT_EN
                        if (r_drain) begin
                            r_drain <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
`else
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`endif
                    end
                end
`ifdef RSCHED_TIMEOUT_EN
                S_DRAIN: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_range_sched.sv
// Directed bench for range_sched: behavioural range-finder core, result scoreboard, protocol checks.
// Runs the timeout/drain scenario as well when RSCHED_TIMEOUT_EN is defined.
module tb_range_sched;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NUM_REQ = 4;
`ifdef RSCHED_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 3;
    localparam int          STALLS  = 2;
`else
    localparam int unsigned TIMEOUT = 15;
    localparam int          STALLS  = 3;
`endif

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         rf_data;
    logic                     rf_go;
    logic                     rf_finish;
    logic [WIDTH-1:0]         rf_range;
    logic                     rf_error;
    logic                     res_valid;
    logic                     res_ready;
    logic [1:0]               res_id;
    logic [WIDTH-1:0]         res_range;
    logic                     res_err;
    logic                     busy;

    range_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
        .rf_range(rf_range), .rf_error(rf_error),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_range(res_range), .res_err(res_err), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] rng;
        logic       err;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Range of a burst: largest sample minus smallest.
    function automatic int burst_range(input int q[$]);
        int lo, hi;
        lo = q[0];
        hi = q[0];
        foreach (q[i]) begin
            if (q[i] < lo) lo = q[i];
            if (q[i] > hi) hi = q[i];
        end
        return hi - lo;
    endfunction

    task automatic expect_res(input int id, input int q[$], input bit err);
        exp_t e;
        e.id  = 2'(id);
        e.rng = 8'(burst_range(q));
        e.err = err;
        sb.push_back(e);
    endtask

    // External range-finder core: tracks min/max from go to finish, range registered after finish.
    logic [7:0] c_min, c_max;
    logic       c_act;
    function automatic logic [7:0] mn(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction
    function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction
    always @(posedge clock) begin
        if (reset) begin
            c_act    <= 1'b0;
            c_min    <= '0;
            c_max    <= '0;
            rf_range <= '0;
        end else if (rf_go) begin
            c_min <= rf_data;
            c_max <= rf_data;
            c_act <= 1'b1;
        end else if (c_act) begin
            c_min <= mn(c_min, rf_data);
            c_max <= mx(c_max, rf_data);
            if (rf_finish) begin
                rf_range <= mx(c_max, rf_data) - mn(c_min, rf_data);
                c_act    <= 1'b0;
            end
        end
    end

    // Every-cycle protocol checks plus scoreboard comparison on each result handshake.
    logic       p_valid = 1'b0, p_ready = 1'b0, p_err = 1'b0;
    logic [1:0] p_id = '0;
    logic [7:0] p_rng = '0;
    always @(negedge clock) begin
        if (reset) begin
            p_valid <= 1'b0;
        end else begin
            chk("go_finish_excl", int'(rf_go & rf_finish), 0);
            if (res_valid) begin
                chk("hold_req_ready", int'(req_ready), 0);
                chk("hold_core_idle", int'(rf_go | rf_finish), 0);
            end
            if (p_valid && !p_ready) begin
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_id_stable", int'(res_id), int'(p_id));
                chk("hold_range_stable", int'(res_range), int'(p_rng));
                chk("hold_err_stable", int'(res_err), int'(p_err));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", int'(res_id), -1);
                end else begin
                    chk("sb_id", int'(res_id), int'(sb[0].id));
                    chk("sb_range", int'(res_range), int'(sb[0].rng));
                    chk("sb_err", int'(res_err), int'(sb[0].err));
                    sb.delete(0);
                end
            end
            p_valid <= res_valid;
            p_ready <= res_ready;
            p_id    <= res_id;
            p_rng   <= res_range;
            p_err   <= res_err;
        end
    end

    // Offer one beat on requester id and wait (bounded) for it to be accepted.
    task automatic beat(input int id, input int d, input bit last,
                        input int exp_go, input int exp_fin, input int exp_data);
        bit done;
        done = 1'b0;
        req_valid[id] = 1'b1;
        req_data[id*WIDTH +: WIDTH] = 8'(d);
        req_last[id] = last;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (req_ready[id]) begin
                done = 1'b1;
                chk("beat_go", int'(rf_go), exp_go);
                chk("beat_finish", int'(rf_finish), exp_fin);
                if (exp_data >= 0) chk("beat_data", int'(rf_data), exp_data);
            end
            @(posedge clock);
            #1;
        end
        if (!done) chk("beat_accept_timeout", int'(done), 1);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_res(input int id, input int rng, input int err);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clock);
            if (res_valid) seen = 1'b1;
        end
        chk("res_seen", int'(seen), 1);
        if (seen) begin
            chk("res_id", int'(res_id), id);
            chk("res_range", int'(res_range), rng);
            chk("res_err", int'(res_err), err);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        res_ready = 1'b1; rf_error = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_go_fin", int'({rf_go, rf_finish}), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_data", int'(rf_data), 0);
        step();
        reset = 1'b0;
        step();

        // Multi-beat burst on req0 with exact result latency.
        q = {5, 9, 2, 7};
        expect_res(0, q, 1'b0);
        beat(0, 5, 1'b0, 1, 0, 5);
        beat(0, 9, 1'b0, 0, 0, 9);
        beat(0, 2, 1'b0, 0, 0, 2);
        beat(0, 7, 1'b1, 0, 1, 7);
        @(negedge clock);
        chk("t1_wait_no_valid", int'(res_valid), 0);
        @(negedge clock);
        chk("t1_valid", int'(res_valid), 1);
        chk("t1_id", int'(res_id), 0);
        chk("t1_range", int'(res_range), 7);
        chk("t1_err", int'(res_err), 0);
        step();

        // Single-beat burst on req2: flush cycle replays the sample with finish.
        q = {42};
        expect_res(2, q, 1'b0);
        beat(2, 42, 1'b1, 1, 0, 42);
        @(negedge clock);
        chk("t2_flush_finish", int'(rf_finish), 1);
        chk("t2_flush_go", int'(rf_go), 0);
        chk("t2_flush_data", int'(rf_data), 42);
        chk("t2_flush_no_valid", int'(res_valid), 0);
        @(negedge clock);
        chk("t2_wait_no_valid", int'(res_valid), 0);
        @(negedge clock);
        chk("t2_valid", int'(res_valid), 1);
        chk("t2_id", int'(res_id), 2);
        chk("t2_range", int'(res_range), 0);
        step();

        // Stalls mid-burst replay the anchor sample.
        q = {10, 50, 30};
        expect_res(1, q, 1'b0);
        beat(1, 10, 1'b0, 1, 0, 10);
        repeat (STALLS) begin
            @(negedge clock);
            chk("t3_stall_data", int'(rf_data), 10);
            chk("t3_stall_go_fin", int'({rf_go, rf_finish}), 0);
            chk("t3_stall_busy", int'(busy), 1);
            step();
        end
        beat(1, 50, 1'b0, 0, 0, 50);
        beat(1, 30, 1'b1, 0, 1, 30);
        wait_res(1, 40, 0);
        step();

        // Reset in STREAM abandons the burst and clears the pointer.
        beat(2, 9, 1'b0, 1, 0, 9);
        beat(2, 11, 1'b0, 0, 0, 11);
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("t6_busy", int'(busy), 0);
        chk("t6_res_valid", int'(res_valid), 0);
        chk("t6_go", int'(rf_go), 0);
        chk("t6_finish", int'(rf_finish), 0);
        step();
        reset = 1'b0;
        step();

        // All requesters contend: grant order 0,1,2,3,0.
        q = {3, 200};   expect_res(0, q, 1'b0);
        q = {100, 90};  expect_res(1, q, 1'b0);
        q = {0, 255};   expect_res(2, q, 1'b0);
        q = {77, 77};   expect_res(3, q, 1'b0);
        q = {250, 5};   expect_res(0, q, 1'b0);
        fork
            begin
                beat(0, 3, 1'b0, 1, 0, 3);   beat(0, 200, 1'b1, 0, 1, 200);
                beat(0, 250, 1'b0, 1, 0, 250); beat(0, 5, 1'b1, 0, 1, 5);
            end
            begin beat(1, 100, 1'b0, 1, 0, 100); beat(1, 90, 1'b1, 0, 1, 90); end
            begin beat(2, 0, 1'b0, 1, 0, 0);     beat(2, 255, 1'b1, 0, 1, 255); end
            begin beat(3, 77, 1'b0, 1, 0, 77);   beat(3, 77, 1'b1, 0, 1, 77); end
        join
        repeat (4) step();
        chk("t4_all_results", sb.size(), 0);

        // Backpressure on the result with a core error during the burst.
        res_ready = 1'b0;
        q = {1, 4};
        expect_res(3, q, 1'b1);
        beat(3, 1, 1'b0, 1, 0, 1);
        rf_error = 1'b1;
        beat(3, 4, 1'b1, 0, 1, 4);
        rf_error = 1'b0;
        req_valid[1] = 1'b1;
        wait_res(3, 3, 1);
        repeat (4) begin
            @(negedge clock);
            chk("t5_hold_valid", int'(res_valid), 1);
            chk("t5_hold_range", int'(res_range), 3);
            chk("t5_hold_ready", int'(req_ready), 0);
            chk("t5_hold_go", int'(rf_go), 0);
        end
        step();
        req_valid[1] = 1'b0;
        res_ready = 1'b1;
        step();
        @(negedge clock);
        chk("t5_released", int'(res_valid), 0);
        step();

`ifdef RSCHED_TIMEOUT_EN
        // Silence after two beats times out, finishes on the anchor, then drains the rest.
        q = {8, 20};
        expect_res(0, q, 1'b1);
        beat(0, 8, 1'b0, 1, 0, 8);
        beat(0, 20, 1'b0, 0, 0, 20);
        repeat (2) begin
            @(negedge clock);
            chk("to_stall_data", int'(rf_data), 8);
            chk("to_stall_finish", int'(rf_finish), 0);
            step();
        end
        @(negedge clock);
        chk("to_fire_data", int'(rf_data), 8);
        chk("to_fire_finish", int'(rf_finish), 1);
        step();
        wait_res(0, 12, 1);
        beat(0, 1, 1'b0, 0, 0, 0);
        beat(0, 2, 1'b1, 0, 0, 0);
        @(negedge clock);
        chk("to_drain_done_busy", int'(busy), 0);
        step();
`endif

        repeat (4) step();
        chk("sb_empty", sb.size(), 0);
        chk("end_busy", int'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
